// File: rtl/dct_coef_bank.sv
// Flop-based DCT coefficient bank with a write port, a random read port and a wrapping burst-read engine.
// Latency: a random read or the first burst word appears 1 cycle after the request. A burst then streams 1 word per cycle.
// Backpressure: none. Requests in BURST are dropped. Define DCT_COEF_BANK_PARITY_EN to add per-word even parity and par_err.
module dct_coef_bank #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 23,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              burst_start,
    input  logic [ADDR_W-1:0] burst_base,
    input  logic [ADDR_W:0]   burst_len,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              burst_busy,
    output logic              burst_done,
`ifdef DCT_COEF_BANK_PARITY_EN
    output logic              par_err,
`endif
    output logic              addr_err
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   LEN_TWO   = (ADDR_W+1)'(2);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_X;
    endfunction

    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [ADDR_W:0]   cnt, cnt_nxt;
    logic              fetch;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              rd_last_nxt;
    logic              burst_done_nxt;
    logic              addr_err_nxt;

    // Storage. Registered reads sample the array before this edge's write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && in_range(wr_addr)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // cnt counts the burst words still owed, including the one on rd_data now.
    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        cnt_nxt        = cnt;
        fetch          = 1'b0;
        fetch_addr     = rd_addr;
        rd_last_nxt    = 1'b0;
        burst_done_nxt = 1'b0;
        addr_err_nxt   = wr_en && !in_range(wr_addr);
        unique case (state)
            IDLE: begin
                if (burst_start) begin
                    if (burst_len == '0) begin
                        burst_done_nxt = 1'b1;
                    end else if (!in_range(burst_base)) begin
                        addr_err_nxt = 1'b1;
                    end else begin
                        state_nxt      = BURST;
                        fetch          = 1'b1;
                        fetch_addr     = burst_base;
                        ptr_nxt        = next_ptr(burst_base);
                        cnt_nxt        = burst_len;
                        rd_last_nxt    = (burst_len == LEN_ONE);
                        burst_done_nxt = (burst_len == LEN_ONE);
                    end
                end else if (rd_en) begin
                    fetch      = 1'b1;
                    fetch_addr = rd_addr;
                    if (!in_range(rd_addr)) begin
                        addr_err_nxt = 1'b1;
                    end
                end
            end
            BURST: begin
                if (cnt == LEN_ONE) begin
                    state_nxt = IDLE;
                end else begin
                    fetch          = 1'b1;
                    fetch_addr     = ptr;
                    ptr_nxt        = next_ptr(ptr);
                    cnt_nxt        = cnt - 1'b1;
                    rd_last_nxt    = (cnt == LEN_TWO);
                    burst_done_nxt = (cnt == LEN_TWO);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fetch_data = in_range(fetch_addr) ? mem[fetch_addr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            burst_done <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            cnt        <= cnt_nxt;
            rd_valid   <= fetch;
            rd_last    <= rd_last_nxt;
            burst_done <= burst_done_nxt;
            addr_err   <= addr_err_nxt;
            if (fetch) begin
                rd_data <= fetch_data;
            end
        end
    end

    assign burst_busy = (state == BURST);

`ifdef DCT_COEF_BANK_PARITY_EN
    logic par_mem [DEPTH];
    logic fetch_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                par_mem[i] <= 1'b0;
            end
        end else if (wr_en && in_range(wr_addr)) begin
            par_mem[wr_addr] <= ^wr_data;
        end
    end

    // An out-of-range read returns zero data, so it never flags parity.
    assign fetch_par = in_range(fetch_addr) ? ((^fetch_data) ^ par_mem[fetch_addr]) : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else begin
            par_err <= fetch && fetch_par;
        end
    end
`endif

endmodule
